// File: rtl/cmd_phy_engine.sv
// SD-host CMD-line PHY: serialises a command with CRC7/end bit, then captures and
// checks an optional short/long response with NCR timeout.
module cmd_phy_engine #(
  parameter int CMD_W        = 40,
  parameter int RESP_SHORT_W = 48,
  parameter int RESP_LONG_W  = 136,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic                   sd_clock,
  input  logic                   reset,
  input  logic                   strobe_in,
  input  logic                   ack_in,
  input  logic                   idle_in,
  input  logic [CMD_W-1:0]       cmd_to_send,
  input  logic [1:0]             resp_type,
  output logic                   ack_out,
  output logic                   strobe_out,
  output logic                   serial_ready,
  output logic [RESP_LONG_W-1:0] response,
  output logic                   command_timeout,
  output logic                   crc_error,
  input  logic                   cmd_pin_in,
  output logic                   cmd_pin_out,
  output logic                   cmd_pin_oe
);

  localparam int SEND_LEN = CMD_W + 8;
  localparam int BIT_MAX  = (SEND_LEN > RESP_LONG_W) ? SEND_LEN : RESP_LONG_W;
  localparam int BCNT_W   = $clog2(BIT_MAX + 1);
  localparam int TCNT_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BCNT_W-1:0] B_CMD   = BCNT_W'(CMD_W);
  localparam logic [BCNT_W-1:0] B_CRC   = BCNT_W'(CMD_W + 7);
  localparam logic [BCNT_W-1:0] B_SEND  = BCNT_W'(SEND_LEN);
  localparam logic [BCNT_W-1:0] B_SHORT = BCNT_W'(RESP_SHORT_W);
  localparam logic [BCNT_W-1:0] B_LONG  = BCNT_W'(RESP_LONG_W);
  localparam logic [TCNT_W-1:0] T_MAX   = TCNT_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECEIVE, DONE} state_t;
  state_t state, state_nxt;

  logic [CMD_W-1:0]  tx_sr;
  logic [1:0]        rtype;
  logic [6:0]        crc;
  logic [BCNT_W-1:0] bcnt, bnum, frame_len, crc_first, crc_last;
  logic [TCNT_W-1:0] tcnt;
  logic              accept, send_last, start_bit, wait_expired, rx_last, crc_on;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Long frames exclude start, dir and the reserved 6 bits from the CRC.
  always_comb begin
    frame_len    = (rtype == 2'b10) ? B_LONG : B_SHORT;
    crc_first    = (rtype == 2'b10) ? BCNT_W'(9) : BCNT_W'(1);
    crc_last     = frame_len - BCNT_W'(8);
    bnum         = bcnt + BCNT_W'(1);
    crc_on       = (bnum >= crc_first) && (bnum <= crc_last);
    accept       = (state == IDLE) && strobe_in && !idle_in;
    send_last    = (state == SEND) && (bcnt == B_SEND);
    start_bit    = (state == WAIT_RESP) && !cmd_pin_in;
    wait_expired = (state == WAIT_RESP) && cmd_pin_in && (tcnt == T_MAX);
    rx_last      = (state == RECEIVE) && (bnum == frame_len);
    state_nxt    = state;
    case (state)
      IDLE:      if (accept) state_nxt = SEND;
      SEND:      if (send_last) state_nxt = (rtype == 2'b00) ? DONE : WAIT_RESP;
      WAIT_RESP: if (start_bit) state_nxt = RECEIVE;
                 else if (wait_expired) state_nxt = DONE;
      RECEIVE:   if (rx_last) state_nxt = DONE;
      DONE:      if (ack_in) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sd_clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      tx_sr           <= '0;
      rtype           <= '0;
      crc             <= '0;
      bcnt            <= '0;
      tcnt            <= '0;
      ack_out         <= 1'b0;
      strobe_out      <= 1'b0;
      serial_ready    <= 1'b0;
      response        <= '0;
      command_timeout <= 1'b0;
      crc_error       <= 1'b0;
      cmd_pin_out     <= 1'b1;
      cmd_pin_oe      <= 1'b0;
    end else begin
      ack_out      <= accept;
      serial_ready <= (state_nxt == IDLE) && !idle_in;
      case (state)
        IDLE: if (accept) begin
          // First payload bit goes out on the accept edge itself.
          tx_sr           <= cmd_to_send << 1;
          rtype           <= resp_type;
          response        <= '0;
          command_timeout <= 1'b0;
          crc_error       <= 1'b0;
          cmd_pin_oe      <= 1'b1;
          cmd_pin_out     <= cmd_to_send[CMD_W-1];
          crc             <= crc7_step(7'h00, cmd_to_send[CMD_W-1]);
          bcnt            <= BCNT_W'(1);
        end
        SEND: begin
          if (bcnt < B_CMD) begin
            cmd_pin_out <= tx_sr[CMD_W-1];
            tx_sr       <= tx_sr << 1;
            crc         <= crc7_step(crc, tx_sr[CMD_W-1]);
            bcnt        <= bnum;
          end else if (bcnt < B_CRC) begin
            cmd_pin_out <= crc[6];
            crc         <= {crc[5:0], 1'b0};
            bcnt        <= bnum;
          end else if (bcnt == B_CRC) begin
            cmd_pin_out <= 1'b1;
            bcnt        <= bnum;
          end else begin
            cmd_pin_oe  <= 1'b0;
            cmd_pin_out <= 1'b1;
            crc         <= '0;
            bcnt        <= '0;
            tcnt        <= '0;
            if (rtype == 2'b00) strobe_out <= 1'b1;
          end
        end
        WAIT_RESP: begin
          if (!cmd_pin_in) begin
            response <= {response[RESP_LONG_W-2:0], cmd_pin_in};
            if (crc_on) crc <= crc7_step(crc, cmd_pin_in);
            bcnt     <= BCNT_W'(1);
          end else if (tcnt == T_MAX) begin
            command_timeout <= 1'b1;
            strobe_out      <= 1'b1;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        RECEIVE: begin
          response <= {response[RESP_LONG_W-2:0], cmd_pin_in};
          if (crc_on) crc <= crc7_step(crc, cmd_pin_in);
          bcnt <= bnum;
          // response[6:0] still holds frame[7:1]; cmd_pin_in is the end bit.
          if (rx_last) begin
            crc_error  <= !cmd_pin_in || ((rtype != 2'b11) && (crc != response[6:0]));
            strobe_out <= 1'b1;
          end
        end
        DONE: if (ack_in) strobe_out <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
